// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 instruction prefetch buffer.
package mips32_pkg;

   localparam logic [5:0]  OPC_HLT          = 6'h3f;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } pf_entry_t;

   function automatic logic is_hlt(word_t instr);
      return instr[31:26] == OPC_HLT;
   endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module mips32_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk1,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Storage is reset too so the outputs read as zero straight out of reset.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mips32_prefetch_buffer.sv
// Instruction prefetch buffer feeding the IF/ID boundary; HLT stop/halted logic is built only
// when MIPS32_PF_HLT_STOP_EN is defined.
module mips32_prefetch_buffer
   import mips32_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic  clk1,
   input  logic  rst_n,
   output logic  imem_req,
   output word_t imem_addr,
   input  word_t imem_rdata,
   input  logic  flush,
   input  word_t flush_pc,
   output logic  out_valid,
   input  logic  out_ready,
   output word_t out_instr,
   output word_t out_pc,
   output logic  halted
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   word_t     fetch_pc_q, fetch_pc_d;
   word_t     req_pc_q, req_pc_d;
   logic      inflight_q, inflight_d;
   logic      stop, hlt_in;
   logic      push, pop;
   logic      fifo_empty, fifo_full;
   logic      credit_ok;
   logic [CW-1:0] count;
   pf_entry_t push_entry, head;

   assign push       = inflight_q && !flush;
   assign pop        = out_valid && out_ready;
   assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

   // Credit counts the outstanding request but not a same-cycle pop, so the FIFO never overflows.
   assign credit_ok = ({1'b0, count} + (CW + 1)'(inflight_q)) < (CW + 1)'(DEPTH);
   assign imem_req  = rst_n && !stop && !hlt_in && !flush && !fifo_full && credit_ok;
   assign imem_addr = fetch_pc_q;

   assign out_valid = !fifo_empty && !flush;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      if (flush) begin
         fetch_pc_d = flush_pc;
      end else if (imem_req) begin
         fetch_pc_d = fetch_pc_q + 32'd1;
         req_pc_d   = fetch_pc_q;
         inflight_d = 1'b1;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

`ifdef MIPS32_PF_HLT_STOP_EN
   logic stop_q, halted_q;

   // An HLT arriving this cycle already blocks the request to the word after it.
   assign hlt_in = push && is_hlt(imem_rdata);
   assign stop   = stop_q;
   assign halted = halted_q;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         stop_q   <= 1'b0;
         halted_q <= 1'b0;
      end else if (flush) begin
         stop_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         if (hlt_in) begin
            stop_q <= 1'b1;
         end
         if (pop && is_hlt(head.instr)) begin
            halted_q <= 1'b1;
         end
      end
   end
`else
   assign hlt_in = 1'b0;
   assign stop   = 1'b0;
   assign halted = 1'b0;
`endif

   mips32_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(pf_entry_t))
   ) u_fifo (
      .clk1  (clk1),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata (push_entry),
      .rdata (head),
      .count (count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule
